// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART states and line-level constants
package uart_pkg;

    localparam int   UART_DATA_BITS   = 8;
    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// rtl/uart_tx_parity_calc.sv - parity bit from latched data and parity type
module uart_tx_parity_calc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  parity_bit
);

    // Even parity makes the total count of ones even; odd inverts it.
    assign parity_bit = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter, parity optional via UART_TX_PARITY_EN
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = UART_DATA_BITS,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      busy
);

    localparam int EDGE_W = PRESCALE_WIDTH - 1;
    localparam int BIT_W  = $clog2(DATA_WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    uart_tx_state_e            state_q, state_d;
    logic [EDGE_W-1:0]         edge_q, edge_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [DATA_WIDTH-1:0]     data_q;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic [PRESCALE_WIDTH-1:0] prescale_m1;
    logic                      bit_end;
    logic                      accept;
    logic                      tx_d;
    logic                      busy_d;
    logic                      parity_bit;

`ifdef UART_TX_PARITY_EN
    logic par_en_q;
    logic par_typ_q;

    uart_tx_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data       (data_q),
        .par_typ    (par_typ_q),
        .parity_bit (parity_bit)
    );
`else
    logic unused_par;
    assign unused_par = PAR_EN ^ PAR_TYP;
    assign parity_bit = UART_IDLE_LEVEL;
`endif

    // Extended by one bit so a prescale of 32 ends at edge_cnt == 31.
    assign prescale_m1 = prescale_q - PRESCALE_WIDTH'(1);
    assign bit_end     = ({1'b0, edge_q} == prescale_m1);
    assign accept      = Data_Valid && ((state_q == IDLE) || ((state_q == STOP) && bit_end));

    // Next state, counters and the next registered line level.
    always_comb begin
        state_d = state_q;
        edge_d  = edge_q;
        bit_d   = bit_q;
        tx_d    = UART_IDLE_LEVEL;
        busy_d  = 1'b1;

        if (state_q != IDLE) begin
            edge_d = bit_end ? '0 : edge_q + EDGE_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (accept) state_d = START;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == LAST_BIT) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = par_en_q ? PARITY : STOP;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_end) state_d = accept ? START : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            edge_d = '0;
            bit_d  = '0;
        end

        case (state_d)
            IDLE:    begin tx_d = UART_IDLE_LEVEL; busy_d = 1'b0; end
            START:   tx_d = UART_START_LEVEL;
            DATA:    tx_d = data_q[bit_d];
            PARITY:  tx_d = parity_bit;
            STOP:    tx_d = UART_IDLE_LEVEL;
            default: begin tx_d = UART_IDLE_LEVEL; busy_d = 1'b0; end
        endcase
    end

    // State, counters and output flops; reset forces the line idle at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            edge_q  <= '0;
            bit_q   <= '0;
            TX_OUT  <= UART_IDLE_LEVEL;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            edge_q  <= edge_d;
            bit_q   <= bit_d;
            TX_OUT  <= tx_d;
            busy    <= busy_d;
        end
    end

    // Request fields are captured only at acceptance so mid-frame changes are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q     <= '0;
            prescale_q <= '0;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
`endif
        end else if (accept) begin
            data_q     <= P_DATA;
            prescale_q <= Prescale;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= PAR_EN;
            par_typ_q  <= PAR_TYP;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic       TX_OUT;
    logic       busy;

    int checks = 0;
    int errors = 0;

    uart_tx #(
        .DATA_WIDTH     (8),
        .PRESCALE_WIDTH (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_tx"}, {31'd0, TX_OUT}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Prescale   = ps;
        Data_Valid = 1'b1;
        @(negedge clk);
    endtask

    // Walks one frame cycle by cycle from its first start-bit cycle, checking
    // each bit's level and that busy holds; optionally pulses a stray request
    // mid-frame or chains the next request on the final stop cycle.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic pe,
                             input logic pt, input int ps, input int inj_bit,
                             input logic chain, input logic [7:0] nd);
        logic [10:0] fb;
        int nbits;
        int bad_tx;
        int bad_busy;
        fb    = '1;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[1+i] = d[i];
        if (pe && PAR_BUILT) begin
            fb[9] = (^d) ^ pt;
            nbits = 11;
        end else begin
            nbits = 10;
        end
        bad_busy = 0;
        for (int b = 0; b < nbits; b++) begin
            bad_tx = 0;
            for (int c = 0; c < ps; c++) begin
                Data_Valid = 1'b0;
                if (TX_OUT !== fb[b]) bad_tx++;
                if (busy !== 1'b1) bad_busy++;
                if (b == inj_bit && c == 1) begin
                    P_DATA     = 8'h00;
                    PAR_EN     = 1'b1;
                    Data_Valid = 1'b1;
                end
                if (chain && b == nbits - 1 && c == ps - 1) begin
                    P_DATA     = nd;
                    Data_Valid = 1'b1;
                end
                @(negedge clk);
            end
            chk($sformatf("%s_bit%0d_bad_cycles", tag, b), bad_tx, 0);
        end
        chk($sformatf("%s_busy_low_cycles", tag), bad_busy, 0);
    endtask

    initial begin
        rst        = 1'b0;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Prescale   = 6'd8;

        repeat (3) @(negedge clk);
        chk_idle("reset_held");
        rst = 1'b1;
        @(negedge clk);
        chk_idle("reset_released");

        // 0xA5, no parity, 8 clocks per bit: 80 busy cycles.
        send(8'hA5, 1'b0, 1'b0, 6'd8);
        run_frame("a5_np", 8'hA5, 1'b0, 1'b0, 8, -1, 1'b0, 8'h00);
        chk_idle("a5_np_end");

        // 0xA5, even parity, 16 clocks per bit.
        send(8'hA5, 1'b1, 1'b0, 6'd16);
        run_frame("a5_even", 8'hA5, 1'b1, 1'b0, 16, -1, 1'b0, 8'h00);
        chk_idle("a5_even_end");

        // 0xA5, odd parity, 16 clocks per bit.
        send(8'hA5, 1'b1, 1'b1, 6'd16);
        run_frame("a5_odd", 8'hA5, 1'b1, 1'b1, 16, -1, 1'b0, 8'h00);
        chk_idle("a5_odd_end");

        // Back-to-back 0x3C then 0xFF without an idle gap.
        send(8'h3C, 1'b0, 1'b0, 6'd8);
        run_frame("b2b_3c", 8'h3C, 1'b0, 1'b0, 8, -1, 1'b1, 8'hFF);
        run_frame("b2b_ff", 8'hFF, 1'b0, 1'b0, 8, -1, 1'b0, 8'h00);
        chk_idle("b2b_end");

        // Stray 0x00 request during data bit 3 of 0x5A is dropped.
        send(8'h5A, 1'b0, 1'b0, 6'd8);
        run_frame("stray_5a", 8'h5A, 1'b0, 1'b0, 8, 4, 1'b0, 8'h00);
        chk_idle("stray_end");
        repeat (20) @(negedge clk);
        chk_idle("stray_not_queued");

        // Reset in the middle of a 0x81 frame, then a clean 0x81 frame.
        send(8'h81, 1'b0, 1'b0, 6'd8);
        Data_Valid = 1'b0;
        repeat (26) @(negedge clk);
        chk("mid_frame_tx", {31'd0, TX_OUT}, 32'd0);
        chk("mid_frame_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk_idle("async_reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle("after_reset");
        send(8'h81, 1'b0, 1'b0, 6'd8);
        run_frame("post_rst_81", 8'h81, 1'b0, 1'b0, 8, -1, 1'b0, 8'h00);
        chk_idle("post_rst_end");

        // 32 clocks per bit exercises the full edge counter wrap.
        send(8'h01, 1'b1, 1'b0, 6'd32);
        run_frame("ps32_01", 8'h01, 1'b1, 1'b0, 32, -1, 1'b0, 8'h00);
        chk_idle("ps32_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
